// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared key codes, state encoding and glyph indices for lock_verify
// Purpose: constants, the FSM state type and small decode helpers used by the
// lock_verify datapath and the seven-segment glyph decoder.
// Ports: none (package).
package lock_pkg;

   // Synchronized key patterns that count as a single-button press (active-low).
   localparam logic [3:0] KEY0 = 4'b1110;
   localparam logic [3:0] KEY1 = 4'b1101;
   localparam logic [3:0] KEY2 = 4'b1011;
   localparam logic [3:0] KEY3 = 4'b0111;

   // 2-bit press codes as stored in ulseq.
   localparam logic [1:0] CODE0 = 2'b00;
   localparam logic [1:0] CODE1 = 2'b01;
   localparam logic [1:0] CODE2 = 2'b10;
   localparam logic [1:0] CODE3 = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      CHECK,
      OPEN,
      ERROR,
      LOCKOUT
   } state_t;

   // Glyph index: 0..9 are the decimal digits, letters follow. Nineteen glyphs
   // need a 5-bit index.
   localparam int GLYPH_W = 5;
   typedef logic [GLYPH_W-1:0] glyph_t;

   localparam glyph_t G_DASH  = 5'd10;
   localparam glyph_t G_BLANK = 5'd11;
   localparam glyph_t G_O     = 5'd12;
   localparam glyph_t G_P     = 5'd13;
   localparam glyph_t G_N     = 5'd14;
   localparam glyph_t G_E     = 5'd15;
   localparam glyph_t G_R     = 5'd16;
   localparam glyph_t G_L     = 5'd17;
   localparam glyph_t G_C     = 5'd18;

   function automatic logic is_single_press(input logic [3:0] k);
      return (k == KEY0) || (k == KEY1) || (k == KEY2) || (k == KEY3);
   endfunction

   function automatic logic [1:0] key_code(input logic [3:0] k);
      logic [1:0] c;
      case (k)
         KEY1:    c = CODE1;
         KEY2:    c = CODE2;
         KEY3:    c = CODE3;
         default: c = CODE0;
      endcase
      return c;
   endfunction

   function automatic glyph_t digit_glyph(input logic [3:0] d);
      return {1'b0, d};
   endfunction

endpackage

// File: rtl/seg7_glyph.sv
// rtl/seg7_glyph.sv - glyph index to active-low seven-segment pattern
// Purpose: pure combinational lookup; segment order is {g,f,e,d,c,b,a}, 0 = lit.
// Ports:
//   i_glyph  in   GLYPH_W  glyph index from lock_pkg
//   o_seg    out  7        active-low segment pattern
module seg7_glyph
   import lock_pkg::*;
(
   input  logic [GLYPH_W-1:0] i_glyph,
   output logic [6:0]         o_seg
);

   always_comb begin
      o_seg = 7'h7F;
      case (i_glyph)
         5'd0:    o_seg = 7'h40;
         5'd1:    o_seg = 7'h79;
         5'd2:    o_seg = 7'h24;
         5'd3:    o_seg = 7'h30;
         5'd4:    o_seg = 7'h19;
         5'd5:    o_seg = 7'h12;
         5'd6:    o_seg = 7'h02;
         5'd7:    o_seg = 7'h78;
         5'd8:    o_seg = 7'h00;
         5'd9:    o_seg = 7'h10;
         G_DASH:  o_seg = 7'h3F;
         G_BLANK: o_seg = 7'h7F;
         G_O:     o_seg = 7'h40;
         G_P:     o_seg = 7'h0C;
         G_N:     o_seg = 7'h2B;
         G_E:     o_seg = 7'h06;
         G_R:     o_seg = 7'h2F;
         G_L:     o_seg = 7'h47;
         G_C:     o_seg = 7'h46;
         default: o_seg = 7'h7F;
      endcase
   end

endmodule

// File: rtl/lock_verify.sv
// rtl/lock_verify.sv - password verification with attempt limit and timed lockout
// Purpose: captures a key sequence, compares it with the latched stored sequence
// and drives unlock/alarm plus LED and seven-segment feedback.
// Ports:
//   clk        in   1          system clock
//   reset      in   1          synchronous, active-high
//   enable     in   1          low forces IDLE (except during LOCKOUT)
//   key        in   4          push buttons, active-low, asynchronous
//   seq_valid  in   1          ulseq holds a completed password
//   ulseq      in   2*nkeys    stored sequence, press i in bits [2i+1:2i]
//   unlocked   out  1          high throughout OPEN
//   alarm      out  1          high throughout LOCKOUT
//   Led        out  4          entry progress / status
//   Hex0..2    out  7 each     active-low seven-segment patterns
module lock_verify
   import lock_pkg::*;
#(
   parameter int nkeys          = 4,
   parameter int max_attempts   = 3,
   parameter int hold_cycles    = 50_000_000,
   parameter int lockout_cycles = 250_000_000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [3:0]           key,
   input  logic                 seq_valid,
   input  logic [2*nkeys-1:0]   ulseq,
   output logic                 unlocked,
   output logic                 alarm,
   output logic [3:0]           Led,
   output logic [6:0]           Hex0,
   output logic [6:0]           Hex1,
   output logic [6:0]           Hex2
);

   localparam logic [3:0]  NKEYS_C   = 4'(nkeys);
   localparam logic [2:0]  MAXA_C    = 3'(max_attempts);
   localparam logic [31:0] HOLD_LAST = 32'(hold_cycles - 1);
   localparam logic [31:0] LOCK_LAST = 32'(lockout_cycles - 1);

   logic [3:0]         r_key_s1;
   logic [3:0]         r_key_s2;
   logic [3:0]         r_kprev;
   logic               r_press;
   logic [1:0]         r_press_code;

   state_t             r_state;
   state_t             w_state_next;
   logic [2*nkeys-1:0] r_ref_seq;
   logic [3:0]         r_cnt;
   logic [2:0]         r_attempts;
   logic               r_mismatch;
   logic [31:0]        r_timer;

   logic [2*nkeys-1:0] w_ref_shift;
   logic [1:0]         w_ref_code;
   logic               w_timer_done;
   logic [2:0]         w_attempts_inc;
   glyph_t             w_g0;
   glyph_t             w_g1;
   glyph_t             w_g2;

   // Two-flop synchronizer followed by a registered edge detector: an event
   // fires only when the previous sample was all-released and the new sample
   // is exactly one button, so holds and chords never repeat or add events.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_key_s1     <= 4'hF;
         r_key_s2     <= 4'hF;
         r_kprev      <= 4'hF;
         r_press      <= 1'b0;
         r_press_code <= CODE0;
      end else begin
         r_key_s1     <= key;
         r_key_s2     <= r_key_s1;
         r_kprev      <= r_key_s2;
         r_press      <= (r_kprev == 4'hF) && is_single_press(r_key_s2);
         r_press_code <= key_code(r_key_s2);
      end
   end

   // Shift rather than index so the select width is independent of nkeys.
   assign w_ref_shift = r_ref_seq >> {r_cnt, 1'b0};
   assign w_ref_code  = w_ref_shift[1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_attempts_inc = r_attempts + 3'd1;
      w_timer_done   = 1'b0;
      unlocked       = 1'b0;
      alarm          = 1'b0;
      Led            = 4'h0;
      w_g2           = G_BLANK;
      w_g1           = G_BLANK;
      w_g0           = G_DASH;
      case (r_state)
         IDLE: begin
            if (enable && seq_valid) w_state_next = ENTRY;
         end
         ENTRY, CHECK: begin
            Led = r_cnt;
            if (r_cnt > 4'd9) begin
               w_g1 = digit_glyph(4'd1);
               w_g0 = digit_glyph(r_cnt - 4'd10);
            end else begin
               w_g0 = digit_glyph(r_cnt);
            end
            if (r_state == ENTRY) begin
               if (!enable) w_state_next = IDLE;
               else if (r_cnt == NKEYS_C) w_state_next = CHECK;
            end else begin
               if (!r_mismatch) w_state_next = OPEN;
               else if (w_attempts_inc == MAXA_C) w_state_next = LOCKOUT;
               else w_state_next = ERROR;
            end
         end
         OPEN: begin
            unlocked     = 1'b1;
            Led          = 4'hF;
            w_g2         = G_O;
            w_g1         = G_P;
            w_g0         = G_N;
            w_timer_done = (r_timer == HOLD_LAST);
            if (!enable || w_timer_done) w_state_next = IDLE;
         end
         ERROR: begin
            w_g2         = G_E;
            w_g1         = G_R;
            w_g0         = G_R;
            w_timer_done = (r_timer == HOLD_LAST);
            if (!enable || w_timer_done) w_state_next = IDLE;
         end
         LOCKOUT: begin
            alarm        = 1'b1;
            w_g2         = G_L;
            w_g1         = G_O;
            w_g0         = G_C;
            w_timer_done = (r_timer == LOCK_LAST);
            if (w_timer_done) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ref_seq  <= '0;
         r_cnt      <= 4'd0;
         r_attempts <= 3'd0;
         r_mismatch <= 1'b0;
         r_timer    <= 32'd0;
      end else begin
         case (r_state)
            IDLE: begin
               r_timer <= 32'd0;
               if (enable && seq_valid) begin
                  r_ref_seq  <= ulseq;
                  r_cnt      <= 4'd0;
                  r_mismatch <= 1'b0;
               end
            end
            ENTRY: begin
               if (enable && r_press && (r_cnt != NKEYS_C)) begin
                  if (r_press_code != w_ref_code) r_mismatch <= 1'b1;
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            CHECK: begin
               r_timer <= 32'd0;
               if (r_mismatch) r_attempts <= w_attempts_inc;
               else r_attempts <= 3'd0;
            end
            OPEN, ERROR: begin
               r_timer <= r_timer + 32'd1;
            end
            LOCKOUT: begin
               r_timer <= r_timer + 32'd1;
               if (w_timer_done) r_attempts <= 3'd0;
            end
            default: r_timer <= 32'd0;
         endcase
      end
   end

   seg7_glyph u_hex0 (.i_glyph(w_g0), .o_seg(Hex0));
   seg7_glyph u_hex1 (.i_glyph(w_g1), .o_seg(Hex1));
   seg7_glyph u_hex2 (.i_glyph(w_g2), .o_seg(Hex2));

endmodule

// File: tb/tb_lock_verify.sv
// tb/tb_lock_verify.sv - self-checking bench for lock_verify against a transaction-level model
module tb_lock_verify;

   localparam int NK   = 4;
   localparam int MAXA = 3;
   localparam int HOLD = 8;
   localparam int LOCK = 20;
   typedef logic [2*NK-1:0] seq_t;
   localparam seq_t REF0 = 8'b11_10_01_00;
   localparam seq_t BAD3 = 8'b11_11_01_00;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [3:0] key;
   logic       seq_valid;
   seq_t       ulseq;
   logic       unlocked;
   logic       alarm;
   logic [3:0] Led;
   logic [6:0] Hex0;
   logic [6:0] Hex1;
   logic [6:0] Hex2;

   int   total = 0;
   int   bad = 0;
   int   attempts_m;
   seq_t ref_m;

   always #5 clk = ~clk;

   lock_verify #(
      .nkeys(NK), .max_attempts(MAXA), .hold_cycles(HOLD), .lockout_cycles(LOCK)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .key(key), .seq_valid(seq_valid),
      .ulseq(ulseq), .unlocked(unlocked), .alarm(alarm), .Led(Led),
      .Hex0(Hex0), .Hex1(Hex1), .Hex2(Hex2)
   );

   function automatic logic [6:0] seg(input byte c);
      case (c)
         "0", "O": return 7'h40;
         "1": return 7'h79;
         "2": return 7'h24;
         "3": return 7'h30;
         "4": return 7'h19;
         "-": return 7'h3F;
         "P": return 7'h0C;
         "n": return 7'h2B;
         "E": return 7'h06;
         "r": return 7'h2F;
         "L": return 7'h47;
         "C": return 7'h46;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [6:0] dig(input int d);
      return seg(byte'(8'h30 + d));
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_key(input int k, input int hold, input int gap);
      key = 4'hF & ~(4'b0001 << k);
      tick(hold);
      key = 4'hF;
      tick(gap);
   endtask

   task automatic wait_entry();
      int n = 0;
      while (!(Led == 4'h0 && Hex0 == dig(0)) && n < 60) begin
         tick(1);
         n++;
      end
      check("entry_reached", 32'(n < 60), 1);
      check("entry_hex1_blank", Hex1, seg(" "));
   endtask

   // mode 0: plain run (random stimulus during lockout); 1: reset in lockout;
   // 2: enable dropped during OPEN/ERROR.
   task automatic run_entry(input seq_t cseq, input int s, input int mode, input bit newref);
      bit   mism;
      int   n, dur, led_max, exp_kind, got_kind;
      bit   cond, side;
      seq_t nxt;
      mism = (cseq != ref_m);
      if (s == 0) wait_entry();
      for (int i = s; i < NK - 1; i++) begin
         press_key(int'(cseq[2*i +: 2]), $urandom_range(1, 6), $urandom_range(4, 8));
         check("led_step", Led, i + 1);
         check("hex0_step", Hex0, dig(i + 1));
         if (newref && i == s) begin
            ulseq     = seq_t'($urandom);
            seq_valid = 1'($urandom);
         end
      end
      key = 4'hF & ~(4'b0001 << cseq[2*(NK-1) +: 2]);
      tick(2);
      key = 4'hF;
      nxt = newref ? seq_t'($urandom) : ref_m;
      ulseq = nxt;
      seq_valid = 1'b1;
      ref_m = nxt;
      if (!mism) begin
         exp_kind = 0;
         attempts_m = 0;
      end else begin
         attempts_m++;
         exp_kind = (attempts_m == MAXA) ? 2 : 1;
      end
      led_max = 0;
      n = 0;
      while (n < 30) begin
         tick(1);
         n++;
         if (unlocked || alarm || Hex2 == seg("E")) break;
         if (int'(Led) > led_max) led_max = int'(Led);
      end
      check("outcome_seen", 32'(n < 30), 1);
      check("led_full", led_max, NK);
      got_kind = unlocked ? 0 : alarm ? 2 : (Hex2 == seg("E")) ? 1 : 3;
      check("outcome_kind", got_kind, exp_kind);
      case (exp_kind)
         0: begin
            check("open_hex", {Hex2, Hex1, Hex0}, {seg("O"), seg("P"), seg("n")});
            check("open_led", Led, 4'hF);
         end
         1: begin
            check("err_hex", {Hex2, Hex1, Hex0}, {seg("E"), seg("r"), seg("r")});
            check("err_led", Led, 4'h0);
         end
         default: check("loc_hex", {Hex2, Hex1, Hex0}, {seg("L"), seg("O"), seg("C")});
      endcase
      dur = 0;
      side = 1'b0;
      while (dur < 100) begin
         cond = (exp_kind == 0) ? unlocked : (exp_kind == 1) ? (Hex2 == seg("E")) : alarm;
         if (!cond) break;
         if (exp_kind != 0 && unlocked) side = 1'b1;
         if (mode == 1 && exp_kind == 2 && dur == 5) begin
            reset = 1'b1;
            tick(1);
            check("rst_lock_led", Led, 0);
            check("rst_lock_alarm", alarm, 0);
            check("rst_lock_unlocked", unlocked, 0);
            check("rst_lock_hex0", Hex0, seg("-"));
            reset = 1'b0;
            attempts_m = 0;
            return;
         end
         if (mode == 2 && exp_kind != 2 && dur == 3) begin
            enable = 1'b0;
            tick(1);
            check("drop_unlocked", unlocked, 0);
            check("drop_hex0", Hex0, seg("-"));
            enable = 1'b1;
            return;
         end
         if (exp_kind == 2 && mode == 0) begin
            if (dur >= 1 && dur < 12) begin
               key = 4'($urandom);
               enable = 1'($urandom);
            end else begin
               key = 4'hF;
               enable = 1'b1;
            end
         end
         tick(1);
         dur++;
      end
      check("outcome_len", dur, (exp_kind == 2) ? LOCK : HOLD);
      check("no_unlock_side", side, 0);
      check("idle_hex0", Hex0, seg("-"));
      check("idle_alarm", alarm, 0);
      check("idle_unlocked", unlocked, 0);
      if (exp_kind == 2) attempts_m = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      seq_t rnd;
      reset = 1'b1;
      enable = 1'b1;
      seq_valid = 1'b1;
      key = 4'hF;
      ulseq = REF0;
      ref_m = REF0;
      attempts_m = 0;
      tick(3);
      check("rst_led", Led, 0);
      check("rst_unlocked", unlocked, 0);
      check("rst_alarm", alarm, 0);
      check("rst_hex", {Hex2, Hex1, Hex0}, {seg(" "), seg(" "), seg("-")});
      reset = 1'b0;

      run_entry(REF0, 0, 0, 1'b0);
      run_entry(BAD3, 0, 0, 1'b0);
      run_entry(BAD3, 0, 0, 1'b0);
      run_entry(BAD3, 0, 0, 1'b0);

      // Long hold then a chord: one event only.
      wait_entry();
      key = 4'b1110;
      tick(30);
      key = 4'b1100;
      tick(5);
      key = 4'hF;
      tick(6);
      check("hold_one_event", Led, 1);
      run_entry(REF0, 1, 0, 1'b0);

      // Reset in the middle of an entry.
      wait_entry();
      press_key(0, 2, 5);
      press_key(1, 2, 5);
      check("pre_rst_led", Led, 2);
      reset = 1'b1;
      tick(1);
      check("rst_entry_led", Led, 0);
      check("rst_entry_hex0", Hex0, seg("-"));
      check("rst_entry_unlocked", unlocked, 0);
      reset = 1'b0;
      attempts_m = 0;

      // Three failures with reset during the lockout.
      run_entry(BAD3, 0, 0, 1'b0);
      run_entry(BAD3, 0, 0, 1'b0);
      run_entry(BAD3, 0, 1, 1'b0);

      // Two failures, success clears attempts, next failure is only ERROR.
      run_entry(BAD3, 0, 0, 1'b0);
      run_entry(BAD3, 0, 0, 1'b0);
      run_entry(REF0, 0, 0, 1'b0);
      run_entry(BAD3, 0, 0, 1'b0);

      // Enable drops during ERROR and OPEN.
      run_entry(BAD3, 0, 2, 1'b0);
      run_entry(REF0, 0, 2, 1'b0);

      // Enable drop during ENTRY discards the partial entry.
      wait_entry();
      press_key(2, 2, 5);
      enable = 1'b0;
      tick(1);
      check("en_drop_led", Led, 0);
      check("en_drop_hex0", Hex0, seg("-"));
      tick(2);
      enable = 1'b1;

      for (int it = 0; it < 20; it++) begin
         rnd = ($urandom_range(0, 1) == 0) ? ref_m : seq_t'($urandom);
         run_entry(rnd, 0, 0, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
